// File: rtl/debugger_tx_serializer_pkg.sv
// debugger_tx_serializer_pkg: shared constants and FSM state type for the debugger tx serializer
package debugger_tx_serializer_pkg;
  localparam int DEF_DBITS = 8;
  localparam int DEF_NBYTES = 215;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/debugger_tx_serializer.sv
// debugger_tx_serializer: captures a wide frame on a send edge and streams it LSB byte first to a UART tx
module debugger_tx_serializer
  import debugger_tx_serializer_pkg::*;
#(
  parameter int NBYTES = DEF_NBYTES,
  parameter int DBITS = DEF_DBITS
) (
  input  logic                    clk,
  input  logic                    global_reset,
  input  logic                    send_signal,
  input  logic [NBYTES*DBITS-1:0] sendData,
  input  logic                    tx_done_tick,
  output logic                    tx_start,
  output logic [DBITS-1:0]        w_data,
  output logic                    busy,
  output logic                    data_sent
);
  localparam int FW = NBYTES * DBITS;
  localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
  state_t state, state_d;
  logic [FW-1:0] shadow, shadow_d;
  logic [CW-1:0] cnt, cnt_d;
  logic send_q, tx_start_d, busy_d, data_sent_d;
  logic [DBITS-1:0] w_data_d;
  logic start;
  assign start = send_signal & ~send_q;
  always_comb begin
    state_d = state;
    shadow_d = shadow;
    cnt_d = cnt;
    tx_start_d = 1'b0;
    w_data_d = w_data;
    busy_d = busy;
    data_sent_d = 1'b0;
    case (state)
      IDLE: begin
        busy_d = start;
        if (start) begin
          shadow_d = sendData;
          cnt_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_start_d = 1'b1;
        w_data_d = shadow[DBITS-1:0];
        state_d = WAIT;
      end
      // a tick coinciding with the registered tx_start pulse belongs to no byte yet
      WAIT: if (tx_done_tick && !tx_start) begin
        if (cnt == LAST) state_d = DONE;
        else begin
          shadow_d = shadow >> DBITS;
          cnt_d = cnt + 1'b1;
          state_d = SEND;
        end
      end
      DONE: begin
        data_sent_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge global_reset) begin
    if (!global_reset) begin
      state <= IDLE;
      shadow <= '0;
      cnt <= '0;
      send_q <= 1'b0;
      tx_start <= 1'b0;
      w_data <= '0;
      busy <= 1'b0;
      data_sent <= 1'b0;
    end else begin
      state <= state_d;
      shadow <= shadow_d;
      cnt <= cnt_d;
      send_q <= send_signal;
      tx_start <= tx_start_d;
      w_data <= w_data_d;
      busy <= busy_d;
      data_sent <= data_sent_d;
    end
  end
endmodule

// File: tb/tb_debugger_tx_serializer.sv
// tb_debugger_tx_serializer: randomized frame tests against a byte-queue reference with a modelled UART
module tb_debugger_tx_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, send, tick, sel;
  logic [31:0] d4;
  logic [1719:0] d2;
  logic ts4, b4, ds4, ts2, b2, ds2;
  logic [7:0] wd4, wd2;
  wire ts = sel ? ts4 : ts2;
  wire [7:0] wd = sel ? wd4 : wd2;
  wire bz = sel ? b4 : b2;
  wire ds = sel ? ds4 : ds2;
  int checks = 0, errors = 0;

  debugger_tx_serializer #(.NBYTES(4)) dut4 (
    .clk(clk), .global_reset(rst_n), .send_signal(sel & send), .sendData(d4),
    .tx_done_tick(sel & tick), .tx_start(ts4), .w_data(wd4), .busy(b4), .data_sent(ds4)
  );
  debugger_tx_serializer dut (
    .clk(clk), .global_reset(rst_n), .send_signal(~sel & send), .sendData(d2),
    .tx_done_tick(~sel & tick), .tx_start(ts2), .w_data(wd2), .busy(b2), .data_sent(ds2)
  );

  function automatic logic [1719:0] rnd_frame();
    logic [1727:0] r;
    for (int i = 0; i < 54; i++) r[i*32 +: 32] = $urandom;
    return r[1719:0];
  endfunction

  task automatic start_frame();
    @(negedge clk);
    send = 1'b1;
  endtask

  // Plays UART: tick 10 cycles after each tx_start; expected bytes come from the frame captured at start.
  task automatic serve(input string name, input int nb, input logic [1719:0] data, input int inject_at,
                       input int abort_at, input bit tick_on_start, input bit hold);
    int idx = 0, cd = -1, last = 0, cyc = 0, nds = 0;
    bit fin = 0, ab = 0;
    while (!fin && !ab && cyc < 12 * nb + 60) begin
      @(negedge clk);
      cyc++;
      tick = 1'b0;
      if (!hold) send = 1'b0;
      if (ts) begin
        checks++;
        if (idx >= nb) begin
          errors++;
          $display("FAIL %s extra_tx_start pulse %0d, allowed %0d", name, idx + 1, nb);
        end else if (wd !== data[idx*8 +: 8]) begin
          errors++;
          $display("FAIL %s byte%0d w_data=%h expected %h", name, idx, wd, data[idx*8 +: 8]);
        end
        checks++;
        if (cyc !== (idx == 0 ? 2 : last + 12)) begin
          errors++;
          $display("FAIL %s byte%0d tx_start cycle=%0d expected %0d", name, idx, cyc, idx == 0 ? 2 : last + 12);
        end
        last = cyc;
        cd = 10;
        if (tick_on_start) tick = 1'b1;
        if (idx == inject_at) begin
          send = 1'b1;
          d4 = $urandom;
          d2 = rnd_frame();
        end
        if (idx == abort_at) begin
          #2 rst_n = 1'b0;
          #1;
          checks++;
          if ({ts, wd, bz, ds} !== 11'd0) begin
            errors++;
            $display("FAIL %s async_reset outputs=%h expected 0", name, {ts, wd, bz, ds});
          end
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ds !== 1'b0) begin
              errors++;
              $display("FAIL %s data_sent_in_reset=%b expected 0", name, ds);
            end
          end
          tick = 1'b0;
          send = 1'b0;
          rst_n = 1'b1;
          ab = 1;
        end
        idx++;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) tick = 1'b1;
      end
      if (!ab && ds) begin
        nds++;
        checks += 3;
        if (idx !== nb) begin errors++; $display("FAIL %s data_sent_after %0d bytes expected %0d", name, idx, nb); end
        if (cyc !== last + 12) begin errors++; $display("FAIL %s data_sent cycle=%0d expected %0d", name, cyc, last + 12); end
        if (bz !== 1'b1) begin errors++; $display("FAIL %s busy_with_data_sent=%b expected 1", name, bz); end
      end else if (!ab && nds > 0) begin
        fin = 1;
        checks++;
        if (bz !== 1'b0) begin errors++; $display("FAIL %s busy_after_done=%b expected 0", name, bz); end
      end
    end
    if (!ab) begin
      checks += 3;
      if (!fin) begin errors++; $display("FAIL %s frame_timeout after %0d cycles, data_sent not seen", name, cyc); end
      if (idx !== nb) begin errors++; $display("FAIL %s pulse_count=%0d expected %0d", name, idx, nb); end
      if (nds !== 1) begin errors++; $display("FAIL %s data_sent_count=%0d expected 1", name, nds); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; send = 1'b0; tick = 1'b0; sel = 1'b1; d4 = '0; d2 = '0;
    #12;
    checks++;
    if ({ts4, wd4, b4, ds4, ts2, wd2, b2, ds2} !== 22'd0) begin
      errors++;
      $display("FAIL reset outputs=%h expected 0", {ts4, wd4, b4, ds4, ts2, wd2, b2, ds2});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ts4, b4, ds4, ts2, b2, ds2} !== 6'd0) begin
      errors++;
      $display("FAIL idle_after_reset outputs=%b expected 0", {ts4, b4, ds4, ts2, b2, ds2});
    end
  endtask

  task automatic test_basic4();
    sel = 1'b1; d4 = 32'hDDCCBBAA;
    start_frame();
    serve("basic4", 4, {1688'd0, 32'hDDCCBBAA}, -1, -1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      logic [31:0] v = $urandom;
      d4 = v;
      start_frame();
      serve("random4", 4, {1688'd0, v}, -1, -1, 0, 0);
    end
  endtask

  task automatic test_default215();
    sel = 1'b0; d2 = {215{8'h06}};
    start_frame();
    serve("const215", 215, {215{8'h06}}, -1, -1, 0, 0);
  endtask

  task automatic test_hold();
    int extra = 0;
    sel = 1'b1; d4 = $urandom;
    begin
      logic [31:0] v = d4;
      start_frame();
      serve("hold_first", 4, {1688'd0, v}, -1, -1, 0, 1);
    end
    for (int i = 0; i < 4900; i++) begin
      @(negedge clk);
      if (ts || bz) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL hold_level activity_cycles=%0d expected 0", extra); end
    send = 1'b0;
    begin
      logic [31:0] v = $urandom;
      d4 = v;
      start_frame();
      serve("hold_second", 4, {1688'd0, v}, -1, -1, 0, 0);
    end
  endtask

  task automatic test_busy_drop();
    logic [31:0] v = $urandom;
    sel = 1'b1; d4 = v;
    start_frame();
    serve("busy_drop", 4, {1688'd0, v}, 2, -1, 0, 0);
    repeat (20) @(negedge clk);
    checks++;
    if (bz !== 1'b0) begin errors++; $display("FAIL busy_drop queued_frame busy=%b expected 0", bz); end
  endtask

  task automatic test_reset_mid();
    logic [1719:0] v = rnd_frame();
    sel = 1'b0; d2 = v;
    start_frame();
    serve("abort215", 215, v, -1, 100, 0, 0);
    v = rnd_frame();
    d2 = v;
    start_frame();
    serve("after_abort215", 215, v, -1, -1, 0, 0);
  endtask

  task automatic test_tick_ignored();
    logic [31:0] v = $urandom;
    sel = 1'b1; d4 = v;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      checks++;
      if ({ts, bz, ds} !== 3'd0) begin errors++; $display("FAIL idle_tick outputs=%b expected 0", {ts, bz, ds}); end
    end
    start_frame();
    serve("tick_on_start", 4, {1688'd0, v}, -1, -1, 1, 0);
  endtask

  initial begin
    test_reset();
    test_basic4();
    test_default215();
    test_hold();
    test_busy_drop();
    test_reset_mid();
    test_tick_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
